// File: rtl/ula_pkg.sv
// Opcodes and FSM states for ula_multiciclo, shared with the control unit.
// ULA_DIV_EN enables the iterative divider; without it opcode 100 is undefined.
package ula_pkg;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;
  localparam logic [2:0] ULA_MUL = 3'b011;
  localparam logic [2:0] ULA_DIV = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } ula_state_t;

  function automatic logic is_iterative(input logic [2:0] op);
`ifdef ULA_DIV_EN
    return (op == ULA_MUL) || (op == ULA_DIV);
`else
    return op == ULA_MUL;
`endif
  endfunction

endpackage

// File: rtl/ula_mul_div.sv
// Shared one-bit-per-cycle engine: unsigned shift-add MUL and (with ULA_DIV_EN) restoring DIV.
// The first step is taken on the start edge, so done rises WIDTH-1 cycles later.
module ula_mul_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, quo_q, b_q;
  logic [WIDTH-1:0] src_acc, src_q, src_b, acc_n, q_n;
  logic [WIDTH:0]   sum_m;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

`ifdef ULA_DIV_EN
  logic             div_q, src_div;
  logic [WIDTH:0]   sh_d, df_d;
`else
  logic             unused_div;
  assign unused_div = is_div;
`endif

  always_comb begin
    src_acc = start ? '0 : acc_q;
    src_q   = start ? a  : quo_q;
    src_b   = start ? b  : b_q;
    // MUL: conditional add, then shift {carry, acc, multiplier} right by one
    sum_m   = {1'b0, src_acc} + (src_q[0] ? {1'b0, src_b} : '0);
    acc_n   = sum_m[WIDTH:1];
    q_n     = {sum_m[0], src_q[WIDTH-1:1]};
`ifdef ULA_DIV_EN
    src_div = start ? is_div : div_q;
    sh_d    = {src_acc, src_q[WIDTH-1]};
    df_d    = sh_d - {1'b0, src_b};
    // divisor 0 never borrows: quotient fills with ones, remainder collects the dividend
    if (src_div) begin
      if (!df_d[WIDTH]) begin
        acc_n = df_d[WIDTH-1:0];
        q_n   = {src_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = sh_d[WIDTH-1:0];
        q_n   = {src_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      quo_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ULA_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start) begin
      acc_q  <= acc_n;
      quo_q  <= q_n;
      b_q    <= b;
      cnt_q  <= CW'(WIDTH - 1);
      busy_q <= 1'b1;
`ifdef ULA_DIV_EN
      div_q  <= is_div;
`endif
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        acc_q <= acc_n;
        quo_q <= q_n;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign lo   = quo_q;
  assign hi   = acc_q;

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with valid/ready handshake, registered results and flags.
// Build with ULA_DIV_EN defined to enable iterative DIV (opcode 100).
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ULAControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ULAResult,
  output logic [WIDTH-1:0] ULAResultHi,
  output logic             flagZ,
  output logic             flagV,
  output logic             op_err
);

  ula_state_t       state_q, state_n;
  logic             accept, start, md_done, divz_q;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [WIDTH-1:0] sum_w, dif_w, alu_res;
  logic             alu_v, alu_err;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign start     = accept && is_iterative(ULAControl);

  ula_mul_div #(.WIDTH(WIDTH)) u_mul_div (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (ULAControl == ULA_DIV),
    .a      (SrcA),
    .b      (SrcB),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum_w   = SrcA + SrcB;
    dif_w   = SrcA - SrcB;
    case (ULAControl)
      ULA_AND: alu_res = SrcA & SrcB;
      ULA_OR:  alu_res = SrcA | SrcB;
      ULA_ADD: begin
        alu_res = sum_w;
        alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_w[WIDTH-1] != SrcA[WIDTH-1]);
      end
      ULA_SUB: begin
        alu_res = dif_w;
        alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (dif_w[WIDTH-1] != SrcA[WIDTH-1]);
      end
      ULA_SLT: alu_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_n = start ? ST_CALC : ST_DONE;
      ST_CALC: if (md_done) state_n = ST_DONE;
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ULAResult   <= '0;
      ULAResultHi <= '0;
      flagZ       <= 1'b0;
      flagV       <= 1'b0;
      op_err      <= 1'b0;
      divz_q      <= 1'b0;
    end else if (accept && !start) begin
      ULAResult   <= alu_res;
      ULAResultHi <= '0;
      flagZ       <= (alu_res == '0);
      flagV       <= alu_v;
      op_err      <= alu_err;
    end else if (start) begin
      divz_q      <= (ULAControl == ULA_DIV) && (SrcB == '0);
    end else if ((state_q == ST_CALC) && md_done) begin
      ULAResult   <= md_lo;
      ULAResultHi <= md_hi;
      flagZ       <= (md_lo == '0);
      flagV       <= 1'b0;
      op_err      <= divz_q;
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo (WIDTH=8): directed literal cases plus randomized traffic checked
// every cycle against an arithmetic latency/result model. Follows ULA_DIV_EN like the RTL.
module tb_ula_multiciclo;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [2:0]   ULAControl = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ULAResult, ULAResultHi;
  logic         flagZ, flagV, op_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .ULAControl  (ULAControl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ULAResult   (ULAResult),
    .ULAResultHi (ULAResultHi),
    .flagZ       (flagZ),
    .flagV       (flagV),
    .op_err      (op_err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the opcode table
  function automatic void model_op(input logic [2:0] op, input int a, input int b,
                                   output int res, output int hi, output int z,
                                   output int v, output int err, output int lat);
    int sa, sb, s;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    res = 0; hi = 0; v = 0; err = 0; lat = 1;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin s = sa + sb; res = (a + b) & 255; v = (s > 127 || s < -128) ? 1 : 0; end
      3'b110: begin s = sa - sb; res = (a - b) & 255; v = (s > 127 || s < -128) ? 1 : 0; end
      3'b111: res = (a < b) ? 1 : 0;
      3'b011: begin res = (a * b) % 256; hi = (a * b) / 256; lat = W + 1; end
`ifdef ULA_DIV_EN
      3'b100: begin
        lat = W + 1;
        if (b == 0) begin res = 255; hi = a; err = 1; end
        else begin res = a / b; hi = a % b; end
      end
`endif
      default: err = 1;
    endcase
    z = (res == 0) ? 1 : 0;
  endfunction

  // Cycle model: acceptance, latency countdown, hold-until-consumed
  bit m_ready = 1'b1, m_valid = 1'b0, m_clear = 1'b1;
  int m_left = 0;
  int m_res = 0, m_hi = 0, m_z = 0, m_v = 0, m_e = 0;
  int p_res, p_hi, p_z, p_v, p_e, p_lat;
  int m_ops = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_ready = 1; m_valid = 0; m_left = 0; m_clear = 1;
      m_res = 0; m_hi = 0; m_z = 0; m_v = 0; m_e = 0;
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 0; m_ready = 1; end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1; m_res = p_res; m_hi = p_hi; m_z = p_z; m_v = p_v; m_e = p_e;
      end
    end else if (m_ready && in_valid) begin
      model_op(ULAControl, int'(SrcA), int'(SrcB), p_res, p_hi, p_z, p_v, p_e, p_lat);
      m_ready = 0; m_clear = 0; m_ops++;
      if (p_lat == 1) begin
        m_valid = 1; m_res = p_res; m_hi = p_hi; m_z = p_z; m_v = p_v; m_e = p_e;
      end else begin
        m_left = p_lat - 1;
      end
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_ready", int'(in_ready), int'(m_ready));
      check("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid || m_clear) begin
        check("ULAResult", int'(ULAResult), m_res);
        check("ULAResultHi", int'(ULAResultHi), m_hi);
        check("flagZ", int'(flagZ), m_z);
        check("flagV", int'(flagV), m_v);
        check("op_err", int'(op_err), m_e);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int er, input int eh, input int ez, input int ev, input int ee,
                        input int elat, input int hold);
    int n, lat;
    ULAControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin @(posedge clk); #1; n++; end
    if (n == 64) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; SrcA = ~a; SrcB = ~b;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1; lat++; SrcA = 8'($urandom);
    end
    check("latency", lat, elat);
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        SrcA = 8'($urandom); SrcB = 8'($urandom); in_valid = 1'b1;
      end
      check("lit_result", int'(ULAResult), er);
      check("lit_result_hi", int'(ULAResultHi), eh);
      check("lit_flagZ", int'(flagZ), ez);
      check("lit_flagV", int'(flagV), ev);
      check("lit_op_err", int'(op_err), ee);
      check("lit_out_valid", int'(out_valid), 1);
      check("lit_in_ready_busy", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", int'(out_valid), 0);
    check("ready_back", int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(ULAResult), 0);
    check("rst_op_err", int'(op_err), 0);

    run_op(3'b000, 8'hF0, 8'h3C, 'h30, 0, 0, 0, 0, 1, 0);
    run_op(3'b001, 8'h00, 8'h00, 'h00, 0, 1, 0, 0, 1, 0);
    run_op(3'b010, 8'h7F, 8'h01, 'h80, 0, 0, 1, 0, 1, 0);
    run_op(3'b110, 8'h05, 8'h05, 'h00, 0, 1, 0, 0, 1, 0);
    run_op(3'b110, 8'h80, 8'h01, 'h7F, 0, 0, 1, 0, 1, 0);
    run_op(3'b111, 8'h03, 8'hF0, 'h01, 0, 0, 0, 0, 1, 0);
    run_op(3'b111, 8'hF0, 8'h03, 'h00, 0, 1, 0, 0, 1, 0);
    run_op(3'b011, 8'hFF, 8'hFF, 'h01, 'hFE, 0, 0, 0, 9, 0);
    run_op(3'b011, 8'h00, 8'h37, 'h00, 0, 1, 0, 0, 9, 0);
`ifdef ULA_DIV_EN
    run_op(3'b100, 8'hC8, 8'h07, 'h1C, 'h04, 0, 0, 0, 9, 0);
    run_op(3'b100, 8'hC8, 8'h00, 'hFF, 'hC8, 0, 0, 1, 9, 0);
`else
    run_op(3'b100, 8'hC8, 8'h07, 'h00, 0, 1, 0, 1, 1, 0);
`endif
    run_op(3'b101, 8'h12, 8'h34, 'h00, 0, 1, 0, 1, 1, 0);

    // Backpressure: result held for 5 extra cycles while inputs churn
    out_ready = 1'b0;
    run_op(3'b010, 8'h7F, 8'h01, 'h80, 0, 0, 1, 0, 1, 5);

    // Reset on the third CALC cycle of a MUL
    ULAControl = 3'b011; SrcA = 8'hFF; SrcB = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_result", int'(ULAResult), 0);
    check("abort_result_hi", int'(ULAResultHi), 0);
    check("abort_flagZ", int'(flagZ), 0);
    check("abort_op_err", int'(op_err), 0);
    run_op(3'b010, 8'h01, 8'h02, 'h03, 0, 0, 0, 0, 1, 0);

    // Random traffic; in_valid also raised while busy, which must be ignored
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      out_ready  = ($urandom % 4) != 0;
      in_valid   = ($urandom % 2) != 0;
      ULAControl = 3'($urandom);
      SrcA       = 8'($urandom);
      SrcB       = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
      rst        = (($urandom % 250) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    if (m_ops < 50) check("random_ops_accepted", m_ops, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
